// File: rtl/mac_reducer_pkg.sv
// rtl/mac_reducer_pkg.sv - shared types and constants for the MAC result reducer
//
// Contents:
//   state_t          ACCUM (collecting samples) / HOLD (group result presented)
//   SUM_MAX/SUM_MIN  signed 32-bit clamp limits
//   COUNT_W          width of the per-group sample counter and out_count
package mac_reducer_pkg;

  localparam int COUNT_W = 9;

  localparam logic signed [31:0] SUM_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SUM_MIN = 32'sh8000_0000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mac_result_reducer_if.sv
// rtl/mac_result_reducer_if.sv - sample-in / group-result-out handshake bundle
//
// Signals:
//   in_valid, in_ready, in_data[31:0], in_last      sample stream into the reducer
//   out_valid, out_ready, out_sum[31:0],
//   out_count[COUNT_W-1:0], out_ovf                 group result stream out
// Modports:
//   master  the side producing samples and consuming results
//   slave   the reducer itself
interface mac_result_reducer_if;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [31:0]                          in_data;
  logic                                 in_last;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [31:0]                          out_sum;
  logic [mac_reducer_pkg::COUNT_W-1:0]  out_count;
  logic                                 out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mac_reducer_sat.sv
// rtl/mac_reducer_sat.sv - clamps a wide signed accumulator to signed 32 bits
//
// Ports:
//   acc  in   ACC_W  signed accumulator value
//   sum  out  32     acc clamped to SUM_MIN..SUM_MAX
//   ovf  out  1      set when clamping changed the value
module mac_reducer_sat
  import mac_reducer_pkg::*;
#(
  parameter int ACC_W = 42
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [31:0]      sum,
  output logic                    ovf
);

  // Limits sign-extended to accumulator width so the comparison is signed.
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SUM_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SUM_MIN);

  always_comb begin
    sum = acc[31:0];
    ovf = 1'b0;
    if (acc > HI) begin
      sum = SUM_MAX;
      ovf = 1'b1;
    end else if (acc < LO) begin
      sum = SUM_MIN;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/mac_result_reducer.sv
// rtl/mac_result_reducer.sv - sums MAC results into groups and emits one result per group
//
// Parameters:
//   GROUP_LEN  samples per group (1..256); in_last may close a group early
//   ACC_W      accumulator width, at least 32 + clog2(GROUP_LEN)
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset; discards any partial group
//   bus  slave modport of mac_result_reducer_if (sample in, group result out)
// Build option:
//   MAC_REDUCER_SAT_EN  defined: out_sum clamps to signed 32 bits, out_ovf flags it
//                       undefined: out_sum wraps to acc[31:0], out_ovf is 0
module mac_result_reducer
  import mac_reducer_pkg::*;
#(
  parameter int GROUP_LEN = 4,
  parameter int ACC_W     = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_result_reducer_if.slave  bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [COUNT_W-1:0]      cnt;
  logic [COUNT_W-1:0]      cnt_inc;
  logic                    accept;
  logic                    close;
  logic [31:0]             conv_sum;
  logic                    conv_ovf;

  // While holding, in_ready follows out_ready so a sample can be taken on the
  // same edge that the pending result leaves.
  assign bus.in_ready  = (state == ACCUM) || bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign accept        = bus.in_valid && bus.in_ready;

  // acc/cnt are cleared whenever a group closes, so in HOLD they are already
  // zero and a sample accepted there naturally starts a fresh group.
  assign acc_sum = acc + ACC_W'(signed'(bus.in_data));
  assign cnt_inc = cnt + COUNT_W'(1);
  assign close   = accept && ((cnt_inc == COUNT_W'(GROUP_LEN)) || bus.in_last);

`ifdef MAC_REDUCER_SAT_EN
  mac_reducer_sat #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc (acc_sum),
    .sum (conv_sum),
    .ovf (conv_ovf)
  );
`else
  assign conv_sum = acc_sum[31:0];
  assign conv_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (close) begin
      state_nxt = HOLD;
    end else if ((state == HOLD) && bus.out_ready) begin
      state_nxt = ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc           <= '0;
        cnt           <= '0;
        bus.out_sum   <= conv_sum;
        bus.out_count <= cnt_inc;
        bus.out_ovf   <= conv_ovf;
      end else begin
        acc <= acc_sum;
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_mac_result_reducer.sv
// tb/tb_mac_result_reducer.sv - directed self-checking bench for mac_result_reducer
module tb_mac_result_reducer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mac_result_reducer_if b4 ();
  mac_result_reducer_if b1 ();

  mac_result_reducer #(.GROUP_LEN(4), .ACC_W(42)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  mac_result_reducer #(.GROUP_LEN(1), .ACC_W(42)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic v, input logic [31:0] s,
                      input logic [8:0] c, input logic o);
    chk({tag, "_valid"}, 32'(b4.out_valid), 32'(v));
    chk({tag, "_sum"},   b4.out_sum,        s);
    chk({tag, "_count"}, 32'(b4.out_count), 32'(c));
    chk({tag, "_ovf"},   32'(b4.out_ovf),   32'(o));
  endtask

  task automatic beat4(input logic [31:0] d, input logic l);
    @(negedge clk);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    b4.in_last  = l;
    @(posedge clk);
  endtask

  task automatic idle4();
    @(negedge clk);
    b4.in_valid = 1'b0;
    b4.in_last  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_last = 1'b0; b4.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk4("rst", 1'b0, 32'd0, 9'd0, 1'b0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(b4.in_ready), 32'd1);

    // full group 1+2+3+4
    beat4(32'd1, 1'b0);
    beat4(32'd2, 1'b0);
    beat4(32'd3, 1'b0);
    beat4(32'd4, 1'b0);
    idle4();
    chk4("grp1234", 1'b1, 32'd10, 9'd4, 1'b0);

    // early close 5 + (-7), then a fresh single-sample group
    beat4(32'd5, 1'b0);
    beat4(32'hFFFF_FFF9, 1'b1);
    idle4();
    chk4("early", 1'b1, 32'hFFFF_FFFE, 9'd2, 1'b0);
    beat4(32'd1, 1'b1);
    idle4();
    chk4("single", 1'b1, 32'd1, 9'd1, 1'b0);

    // overflow: 4 x 0x7FFFFFFF
    for (int i = 0; i < 4; i++) beat4(32'h7FFF_FFFF, 1'b0);
    idle4();
`ifdef MAC_REDUCER_SAT_EN
    chk4("ovf", 1'b1, 32'h7FFF_FFFF, 9'd4, 1'b1);
`else
    chk4("ovf", 1'b1, 32'hFFFF_FFFC, 9'd4, 1'b0);
`endif

    // back-pressure: group closes with out_ready low, next sample waits
    beat4(32'd10, 1'b0);
    beat4(32'd20, 1'b0);
    beat4(32'd30, 1'b0);
    @(negedge clk);
    b4.in_valid  = 1'b1;
    b4.in_data   = 32'd40;
    b4.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b4.in_data = 32'd50;
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", 32'(b4.in_ready), 32'd0);
      chk4("hold", 1'b1, 32'd100, 9'd4, 1'b0);
      if (i < 4) @(negedge clk);
    end
    b4.out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(b4.in_ready), 32'd1);
    @(posedge clk);
    beat4(32'd60, 1'b0);
    beat4(32'd70, 1'b0);
    beat4(32'd80, 1'b0);
    idle4();
    chk4("after_hold", 1'b1, 32'd260, 9'd4, 1'b0);

    // asynchronous reset mid-group discards the partial sum
    beat4(32'd100, 1'b0);
    beat4(32'd100, 1'b0);
    idle4();
    #2 rst = 1'b1;
    #1 chk4("async_rst", 1'b0, 32'd0, 9'd0, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) beat4(32'd1, 1'b0);
    idle4();
    chk4("post_rst", 1'b1, 32'd4, 9'd4, 1'b0);

    // GROUP_LEN = 1: back-to-back beats 7, 8, 9
    @(negedge clk);
    b1.in_valid = 1'b1;
    b1.in_data  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("g1_valid_7", 32'(b1.out_valid), 32'd1);
    chk("g1_sum_7",   b1.out_sum,        32'd7);
    chk("g1_cnt_7",   32'(b1.out_count), 32'd1);
    chk("g1_rdy_7",   32'(b1.in_ready),  32'd1);
    b1.in_data = 32'd8;
    @(posedge clk);
    @(negedge clk);
    chk("g1_valid_8", 32'(b1.out_valid), 32'd1);
    chk("g1_sum_8",   b1.out_sum,        32'd8);
    chk("g1_cnt_8",   32'(b1.out_count), 32'd1);
    chk("g1_rdy_8",   32'(b1.in_ready),  32'd1);
    b1.in_data = 32'd9;
    @(posedge clk);
    @(negedge clk);
    chk("g1_valid_9", 32'(b1.out_valid), 32'd1);
    chk("g1_sum_9",   b1.out_sum,        32'd9);
    chk("g1_cnt_9",   32'(b1.out_count), 32'd1);
    b1.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("g1_drain", 32'(b1.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
